// File: rtl/src_feeder_pkg.sv
// Shared types for the source-stream feeder: FSM states, skid entry, default widths.
// No logic; no latency.
// No flow control of its own.
package src_feeder_pkg;
    localparam int SF_DW  = 16;
    localparam int SF_AW  = 12;
    localparam int SF_FW  = 8;
    localparam int SF_SSW = 12;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [SF_DW-1:0] data;
        logic             last;
    } skid_ent_t;
endpackage

// File: rtl/src_skid2.sv
// Two-entry skid buffer with empty-bypass; occupancy exported for read crediting.
// Latency: 0 cycles when empty (bypass), else FIFO order from the head entry.
// Backpressure: holds up to 2 words while rd_rdy is low; the writer must never push when full.
module src_skid2
    import src_feeder_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      wr_vld,
    input  skid_ent_t wr_ent,
    input  logic      rd_rdy,
    output logic      rd_vld,
    output skid_ent_t rd_ent,
    output logic [1:0] occ
);
    skid_ent_t  ent_q [2];
    logic       head_q, tail_q;
    logic [1:0] occ_q;
    logic       empty, bypass, push, pop;

    assign empty  = (occ_q == 2'd0);
    // An arriving word goes straight out when nothing is queued ahead of it.
    assign bypass = empty & wr_vld & rd_rdy;
    assign push   = wr_vld & ~bypass;
    assign pop    = ~empty & rd_rdy;
    assign rd_vld = ~empty | wr_vld;
    assign rd_ent = !empty ? ent_q[head_q] : (wr_vld ? wr_ent : '0);
    assign occ    = occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush) begin
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                ent_q[tail_q] <= wr_ent;
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            occ_q <= occ_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/src_feeder.sv
// Reads (ss+1)*(nf+1) words from a sync-read buffer and streams them with src_last per frame.
// Latency: start -> mem_re next cycle -> src_valid one cycle later; 1 word/cycle at full rate.
// Backpressure: src_ready low stalls reads once 2 words are in flight/held. Option: SRC_FEEDER_STALL_CNT_EN.
module src_feeder
    import src_feeder_pkg::*;
#(
    parameter int DW = SF_DW,
    parameter int AW = SF_AW,
    parameter int FW = SF_FW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base,
    input  logic [11:0]   ss,
    input  logic [FW-1:0] nf,
    output logic          busy,
    output logic          done,
    output logic          mem_re,
    output logic [AW-1:0] mem_a,
    input  logic [DW-1:0] mem_d,
    output logic          src_valid,
    output logic [DW-1:0] src_data,
    output logic          src_last,
    input  logic          src_ready
`ifdef SRC_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    state_t        state_q, state_n;
    logic [AW-1:0] addr_q;
    logic [11:0]   wi_q, ss_q;
    logic [FW-1:0] fc_q, nf_q;
    logic          rd_vld_q, rd_last_q;
    logic [1:0]    occ, held;
    logic          accept, kill, end_frame, last_issue, xfer;
    skid_ent_t     wr_ent, head_ent;

    assign accept     = (state_q == IDLE) & start & ~abort;
    assign kill       = (state_q != IDLE) & abort;
    assign end_frame  = (wi_q == ss_q);
    assign last_issue = mem_re & end_frame & (fc_q == nf_q);
    // Words already committed: read data arriving now plus words parked in the skid.
    assign held       = {1'b0, rd_vld_q} + occ;
    assign xfer       = src_valid & src_ready;
    assign mem_a      = addr_q;
    assign wr_ent     = '{data: mem_d, last: rd_last_q};
    assign src_data   = head_ent.data;
    assign src_last   = head_ent.last;

    always_comb begin
        state_n = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        mem_re  = (state_q == RUN) & ~abort & (held < 2'd2);
        unique case (state_q)
            IDLE:    if (accept) state_n = RUN;
            RUN:     if (abort) state_n = IDLE;
                     else if (last_issue) state_n = DRAIN;
            DRAIN:   if (abort) state_n = IDLE;
                     else if (xfer && held == 2'd1) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wi_q      <= '0;
            fc_q      <= '0;
            ss_q      <= '0;
            nf_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            rd_vld_q  <= mem_re;
            rd_last_q <= end_frame;
            if (accept) begin
                addr_q <= base;
                ss_q   <= ss;
                nf_q   <= nf;
                wi_q   <= '0;
                fc_q   <= '0;
            end else if (mem_re) begin
                addr_q <= addr_q + AW'(1);
                if (end_frame) begin
                    wi_q <= '0;
                    fc_q <= fc_q + FW'(1);
                end else begin
                    wi_q <= wi_q + 12'd1;
                end
            end
        end
    end

    src_skid2 u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (kill),
        .wr_vld (rd_vld_q),
        .wr_ent (wr_ent),
        .rd_rdy (src_ready),
        .rd_vld (src_valid),
        .rd_ent (head_ent),
        .occ    (occ)
    );

`ifdef SRC_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || accept)
            stall_cnt <= 16'd0;
        else if (busy && src_valid && !src_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_src_feeder.sv
// Scoreboard bench for src_feeder: stimulus queues expected reads/words, a negedge monitor checks them.
module tb_src_feeder;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, src_ready;
    logic [11:0] base, ss;
    logic [7:0]  nf;
    logic        busy, done, mem_re, src_valid, src_last;
    logic [11:0] mem_a;
    logic [15:0] mem_d, src_data;
`ifdef SRC_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    src_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base(base), .ss(ss), .nf(nf), .busy(busy), .done(done),
        .mem_re(mem_re), .mem_a(mem_a), .mem_d(mem_d),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready)
`ifdef SRC_FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    logic [15:0] mem [4096];
    always @(posedge clk) if (mem_re) mem_d <= mem[mem_a];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [16:0] exp_q[$];
    logic [11:0] addr_q[$];
    bit          clr = 0, chk_en = 1;
    int          xfer_cnt, first_cyc, last_cyc, done_cnt, done_cyc, busy_cnt, pend, max_pend, s_cyc;
    bit          stl;
    logic [16:0] stl_word;

    always @(negedge clk) begin
        if (clr) begin
            xfer_cnt = 0; done_cnt = 0; busy_cnt = 0; pend = 0; max_pend = 0; stl = 0;
        end
        if (rst_n) begin
            if (mem_re) begin
                chk("read_expected", 32'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) chk("mem_a", 32'(mem_a), 32'(addr_q.pop_front()));
                pend++;
            end
            if (chk_en && stl) chk("hold", {src_valid, src_last, src_data}, {1'b1, stl_word});
            if (src_valid && src_ready) begin
                chk("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("word", {src_last, src_data}, 32'(exp_q.pop_front()));
                if (xfer_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_cnt++;
                pend--;
            end
            stl      = src_valid && !src_ready;
            stl_word = {src_last, src_data};
            if (pend > max_pend) max_pend = pend;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_lat", 32'(cyc), 32'(last_cyc + 1));
                chk("done_all", 32'(exp_q.size()), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] b, input logic [11:0] s, input logic [7:0] n);
        logic [11:0] a;
        for (int f = 0; f <= int'(n); f++)
            for (int w = 0; w <= int'(s); w++) begin
                a = b + 12'(f * (int'(s) + 1) + w);
                addr_q.push_back(a);
                exp_q.push_back({w == int'(s), mem[a]});
            end
        base = b; ss = s; nf = n; start = 1'b1; clr = 1'b1; s_cyc = cyc;
        tick();
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin ok = 1; break; end
            src_ready = toggle ? ~src_ready : 1'b1;
            tick();
        end
        chk("done_seen", 32'(ok), 1);
        src_ready = 1'b1;
        tick();
    endtask

    task automatic wait_xfers(input int n, input string nm);
        for (int i = 0; i < 100 && xfer_cnt < n; i++) tick();
        chk(nm, 32'(xfer_cnt >= n), 1);
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_mem_re"}, mem_re, 0);
        chk({pfx, "_mem_a"}, mem_a, 0);
        chk({pfx, "_valid"}, src_valid, 0);
        chk({pfx, "_data"}, src_data, 0);
        chk({pfx, "_last"}, src_last, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 3 + 16'h1000);
        rst_n = 0; start = 0; abort = 0; src_ready = 1; base = 0; ss = 0; nf = 0;
        tick(); tick();
        chk_idle_outputs("reset");
        rst_n = 1;
        tick();

        // 2 frames of 4 words, full rate
        issue(12'h010, 12'd3, 8'd1);
        wait_done(0);
        chk("t1_first_lat", 32'(first_cyc - s_cyc), 2);
        chk("t1_done_lat", 32'(done_cyc - s_cyc), 10);
        chk("t1_xfers", 32'(xfer_cnt), 8);
        chk("t1_done_cnt", 32'(done_cnt), 1);

        // same command with src_ready toggling
        issue(12'h010, 12'd3, 8'd1);
        wait_done(1);
        chk("t2_xfers", 32'(xfer_cnt), 8);
        chk("t2_inflight_le2", 32'(max_pend <= 2), 1);
        chk("t2_done_cnt", 32'(done_cnt), 1);

        // single word
        issue(12'h020, 12'd0, 8'd0);
        wait_done(0);
        chk("t3_busy_cycles", 32'(busy_cnt), 3);
        chk("t3_done_lat", 32'(done_cyc - s_cyc), 3);
        chk("t3_xfers", 32'(xfer_cnt), 1);
        chk("t3_done_cnt", 32'(done_cnt), 1);

        // address wrap FFE,FFF,000,001
        issue(12'hFFE, 12'd3, 8'd0);
        wait_done(0);
        chk("t4_xfers", 32'(xfer_cnt), 4);
        chk("t4_reads_left", 32'(addr_q.size()), 0);

        // abort after 5 transfers of a 16-word command
        issue(12'h100, 12'd15, 8'd0);
        wait_xfers(5, "t5_reach5");
        chk_en = 0; abort = 1; src_ready = 0;
        tick();
        abort = 0;
        chk("t5_valid", src_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_xfers", 32'(xfer_cnt), 5);
        exp_q.delete(); addr_q.delete();
        tick(); tick(); tick();
        chk("t5_no_done", 32'(done_cnt), 0);
        chk("t5_no_reads", 32'(addr_q.size()), 0);
        chk_en = 1; src_ready = 1;
        issue(12'h200, 12'd7, 8'd1);
        wait_done(0);
        chk("t5b_xfers", 32'(xfer_cnt), 16);
        chk("t5b_done_lat", 32'(done_cyc - s_cyc), 18);

        // synchronous reset mid-run
        issue(12'h400, 12'd7, 8'd0);
        wait_xfers(2, "t6_reach2");
        chk("t6_valid_before", src_valid, 1);
        chk_en = 0; rst_n = 0;
        tick();
        chk_idle_outputs("t6");
        rst_n = 1;
        exp_q.delete(); addr_q.delete();
        tick(); tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_no_done", 32'(done_cnt), 0);
        chk_en = 1;

`ifdef SRC_FEEDER_STALL_CNT_EN
        issue(12'h300, 12'd15, 8'd0);
        wait_xfers(3, "t7_reach3");
        src_ready = 0;
        repeat (10) tick();
        src_ready = 1;
        wait_done(0);
        chk("t7_stall_cnt", stall_cnt, 10);
        chk("t7_xfers", 32'(xfer_cnt), 16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/src_feeder.md
Name: src_feeder

Overview:
- Transmit end of the accelerator source stream: reads frames from a synchronous-read local buffer and drives src_valid/src_data/src_last into the batch controller, honouring src_ready backpressure.
- One frame = ss+1 words; nf+1 frames per command; src_last marks the final word of every frame.
- Sits between the host-loaded input buffer and the batch controller source port.

Parameters:
- DW, 16, data word width
- AW, 12, buffer address width
- FW, 8, frame-count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  command pulse; sampled only in IDLE
- abort  in  1  cancel current command; returns to IDLE next cycle
- base  in  AW  start address of frame 0
- ss  in  12  words per frame minus 1
- nf  in  FW  frames per command minus 1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last word handshakes
- mem_re  out  1  buffer read enable
- mem_a  out  AW  buffer read address
- mem_d  in  DW  read data, valid exactly 1 cycle after mem_re
- src_valid  out  1  stream word valid
- src_data  out  DW  stream word
- src_last  out  1  final word of a frame
- src_ready  in  1  sink ready; transfer = src_valid&src_ready

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, mem_re=0, mem_a=0, src_valid=0, src_data=0, src_last=0; counters and skid buffer cleared.
- States: IDLE -> RUN on start (latch base, ss, nf; wi=0, fc=0, addr=base); RUN -> DRAIN when the last read is issued; DRAIN -> DONE when the skid buffer is empty and the last word has been transferred; DONE -> IDLE unconditionally (done=1 for exactly that cycle).
- Read issue: in RUN, mem_re=1 when (outstanding reads + skid occupancy) < 2, so at most 2 words are in flight/held. mem_a=addr; on issue addr+=1 (mod 2^AW, wraps silently), wi+=1; when wi==ss: wi=0, fc+=1; issue of wi==ss with fc==nf is the last read.
- Per-word tag: last flag = (wi==ss) at issue; it travels with the word down the read pipeline.
- Skid buffer: 2 entries {data,last}; written the cycle mem_d is valid; head drives src_data/src_last, src_valid = not empty. Simultaneous write and pop permitted at occupancy 1 or 2, occupancy unchanged. No push to full occurs, by credit rule.
- Throughput: with src_ready held high, one word per cycle after 2-cycle start latency (start at cycle 0 -> mem_re at 1 -> src_valid at 2).
- src_valid, once asserted, stays asserted with stable src_data/src_last until handshake (no retraction except abort/reset).
- abort (any non-IDLE state): next cycle IDLE, src_valid=0, skid flushed, in-flight read data discarded; no done pulse. abort in IDLE is ignored. abort with start in the same cycle: abort wins.
- start while not IDLE is ignored.
- ss=0: every word carries src_last. nf=0, ss=0: exactly one word, done 1 cycle after its handshake.
- Counter widths: wi 12 bits, fc FW bits; comparisons are equality only.

Optional Feature:
- Macro SRC_FEEDER_STALL_CNT_EN.
- Defined: extra output port stall_cnt (out, 16) counts cycles with src_valid&~src_ready during busy; clears on accepted start; saturates at 16'hFFFF; holds after done; 0 on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: state enum (IDLE, RUN, DRAIN, DONE), skid-entry struct {data, last}, width constants DW/AW/FW defaults.
- One natural sub-module: src_skid2, the 2-entry skid buffer with occupancy output for the credit check.

Test Plan:
- base=12'h010, ss=3, nf=1, src_ready=1 -> mem_a 0x010..0x017 consecutive; 8 transfers on consecutive cycles from cycle 2; src_last on words 3 and 7; done pulse cycle after word 7.
- Same command, src_ready toggling 1/0 -> data order and values unchanged; src_valid never drops before handshake; at most 2 reads outstanding.
- ss=0, nf=0 -> single word with src_last=1; busy for 3 cycles; one done pulse.
- base=12'hFFE, ss=3, nf=0 -> mem_a FFE, FFF, 000, 001.
- abort asserted after 5 transfers of a 16-word command -> IDLE next cycle, src_valid=0, no done; a following start runs the full new command cleanly.
- rst_n=0 mid-RUN with src_valid high -> all outputs reset values next cycle. With SRC_FEEDER_STALL_CNT_EN, src_ready=0 for 10 cycles mid-frame -> stall_cnt=10.
